// File: rtl/priv32_wb_arbiter.sv
// Writeback arbiter for the priv32 core: round-robin between the execute
// unit and the load/store unit onto a single registered register-file write
// port, plus a per-register scoreboard of outstanding writes used for
// operand hazard detection.
module priv32_wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            issue_valid_i,
   input  logic [4:0]      issue_rd_i,
   input  logic            ex_valid_i,
   input  logic [4:0]      ex_rd_i,
   input  logic [XLEN-1:0] ex_data_i,
   output logic            ex_ready_o,
   input  logic            ls_valid_i,
   input  logic [4:0]      ls_rd_i,
   input  logic [XLEN-1:0] ls_data_i,
   output logic            ls_ready_o,
   output logic            we_o,
   output logic [4:0]      waddr_o,
   output logic [XLEN-1:0] wdata_o,
   input  logic [4:0]      raddr1_i,
   input  logic [4:0]      raddr2_i,
   output logic            busy1_o,
   output logic            busy2_o,
   output logic [31:0]     pending_o
);

   typedef enum logic {
      GRANT_EX = 1'b0,
      GRANT_LS = 1'b1
   } grant_e;

   grant_e          last_grant_q, last_grant_d;
   logic            we_q, we_d;
   logic [4:0]      waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [31:0]     pending_q, pending_d;

   logic            ex_ready, ls_ready;
   logic            acc;
   logic [4:0]      acc_rd;
   logic [XLEN-1:0] acc_data;

   // Grant: a lone requester wins at once; on conflict the one not served last wins.
   always_comb begin
      ex_ready = 1'b0;
      ls_ready = 1'b0;
      if (!rst_in) begin
         if (ex_valid_i && ls_valid_i) begin
            if (last_grant_q == GRANT_LS) ex_ready = 1'b1;
            else                          ls_ready = 1'b1;
         end else if (ex_valid_i) begin
            ex_ready = 1'b1;
         end else if (ls_valid_i) begin
            ls_ready = 1'b1;
         end
      end
   end

   // Select the accepted transfer (ready is only ever raised alongside its valid).
   always_comb begin
      acc      = ex_ready | ls_ready;
      acc_rd   = ls_ready ? ls_rd_i   : ex_rd_i;
      acc_data = ls_ready ? ls_data_i : ex_data_i;
   end

   // Next state: arbitration history, write port and scoreboard.
   always_comb begin
      last_grant_d = last_grant_q;
      if (ex_ready)      last_grant_d = GRANT_EX;
      else if (ls_ready) last_grant_d = GRANT_LS;

      // A write to x0 is consumed but never reaches the register file;
      // address and data then keep their previous values.
      we_d    = acc && (acc_rd != 5'd0);
      waddr_d = we_d ? acc_rd   : waddr_q;
      wdata_d = we_d ? acc_data : wdata_q;

      // Clear first so that a same-cycle issue to the same register wins.
      pending_d = pending_q;
      if (we_d) pending_d[acc_rd] = 1'b0;
      if (issue_valid_i && (issue_rd_i != 5'd0)) pending_d[issue_rd_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   // State register with synchronous reset; EX wins the first conflict after reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_grant_q <= GRANT_LS;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         pending_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         pending_q    <= pending_d;
      end
   end

   assign ex_ready_o = ex_ready;
   assign ls_ready_o = ls_ready;
   assign we_o       = we_q;
   assign waddr_o    = waddr_q;
   assign wdata_o    = wdata_q;
   assign pending_o  = pending_q;
   assign busy1_o    = (raddr1_i != 5'd0) && pending_q[raddr1_i];
   assign busy2_o    = (raddr2_i != 5'd0) && pending_q[raddr2_i];

endmodule

// File: tb/tb_priv32_wb_arbiter.sv
// Bench for priv32_wb_arbiter: table of per-cycle vectors with expected
// readies/busy flags, a queue of expected write-port/scoreboard results,
// and hand-written sequences for sustained conflicts and mid-run reset.
module tb_priv32_wb_arbiter;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_in;
   logic            issue_valid_i;
   logic [4:0]      issue_rd_i;
   logic            ex_valid_i;
   logic [4:0]      ex_rd_i;
   logic [XLEN-1:0] ex_data_i;
   logic            ex_ready_o;
   logic            ls_valid_i;
   logic [4:0]      ls_rd_i;
   logic [XLEN-1:0] ls_data_i;
   logic            ls_ready_o;
   logic            we_o;
   logic [4:0]      waddr_o;
   logic [XLEN-1:0] wdata_o;
   logic [4:0]      raddr1_i;
   logic [4:0]      raddr2_i;
   logic            busy1_o;
   logic            busy2_o;
   logic [31:0]     pending_o;

   priv32_wb_arbiter #(.XLEN(XLEN)) dut (
      .clk_in(clk), .rst_in(rst_in),
      .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
      .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i), .ex_ready_o(ex_ready_o),
      .ls_valid_i(ls_valid_i), .ls_rd_i(ls_rd_i), .ls_data_i(ls_data_i), .ls_ready_o(ls_ready_o),
      .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .raddr1_i(raddr1_i), .raddr2_i(raddr2_i), .busy1_o(busy1_o), .busy2_o(busy2_o),
      .pending_o(pending_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ex_v;  logic [4:0] ex_rd;  logic [31:0] ex_d;
      logic        ls_v;  logic [4:0] ls_rd;  logic [31:0] ls_d;
      logic        iss_v; logic [4:0] iss_rd;
      logic [4:0]  ra1;   logic [4:0] ra2;
      logic        exp_ex; logic exp_ls; logic exp_b1; logic exp_b2;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pending;
   } wb_t;

   wb_t         sb_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] m_pending;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, check combinational outputs, then check the
   // registered results after the rising edge against the scoreboard queue.
   task automatic step(input vec_t v);
      wb_t e, g;
      logic [4:0]  a_rd;
      logic [31:0] a_d;
      @(negedge clk);
      ex_valid_i = v.ex_v;  ex_rd_i = v.ex_rd;  ex_data_i = v.ex_d;
      ls_valid_i = v.ls_v;  ls_rd_i = v.ls_rd;  ls_data_i = v.ls_d;
      issue_valid_i = v.iss_v; issue_rd_i = v.iss_rd;
      raddr1_i = v.ra1; raddr2_i = v.ra2;
      #1;
      check("ex_ready", {31'd0, ex_ready_o}, {31'd0, v.exp_ex});
      check("ls_ready", {31'd0, ls_ready_o}, {31'd0, v.exp_ls});
      check("one_hot_ready", {31'd0, ex_ready_o & ls_ready_o}, 32'd0);
      check("busy1", {31'd0, busy1_o}, {31'd0, v.exp_b1});
      check("busy2", {31'd0, busy2_o}, {31'd0, v.exp_b2});
      // expected effect of this cycle
      a_rd = v.exp_ls ? v.ls_rd : v.ex_rd;
      a_d  = v.exp_ls ? v.ls_d  : v.ex_d;
      e.we = (v.exp_ex | v.exp_ls) && (a_rd != 5'd0);
      if (e.we) begin
         m_waddr = a_rd;
         m_wdata = a_d;
         m_pending[a_rd] = 1'b0;
      end
      if (v.iss_v && v.iss_rd != 5'd0) m_pending[v.iss_rd] = 1'b1;
      e.waddr = m_waddr; e.wdata = m_wdata; e.pending = m_pending;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_cmp++; n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         g = sb_q.pop_front();
         check("we",      {31'd0, we_o}, {31'd0, g.we});
         check("waddr",   {27'd0, waddr_o}, {27'd0, g.waddr});
         check("wdata",   wdata_o, g.wdata);
         check("pending", pending_o, g.pending);
      end
   endtask

   function automatic vec_t mk(input logic ex_v, input logic [4:0] ex_rd, input logic [31:0] ex_d,
                               input logic ls_v, input logic [4:0] ls_rd, input logic [31:0] ls_d,
                               input logic iss_v, input logic [4:0] iss_rd,
                               input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic xe, input logic xl, input logic b1, input logic b2);
      vec_t v;
      v.ex_v = ex_v; v.ex_rd = ex_rd; v.ex_d = ex_d;
      v.ls_v = ls_v; v.ls_rd = ls_rd; v.ls_d = ls_d;
      v.iss_v = iss_v; v.iss_rd = iss_rd; v.ra1 = ra1; v.ra2 = ra2;
      v.exp_ex = xe; v.exp_ls = xl; v.exp_b1 = b1; v.exp_b2 = b2;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_in = 1'b1;
      ex_valid_i = 1'b1; ex_rd_i = 5'd6; ex_data_i = 32'h6666_6666;
      ls_valid_i = 1'b1; ls_rd_i = 5'd9; ls_data_i = 32'h9999_9999;
      issue_valid_i = 1'b1; issue_rd_i = 5'd12;
      raddr1_i = 5'd0; raddr2_i = 5'd0;
      #1;
      check("rst_ex_ready", {31'd0, ex_ready_o}, 32'd0);
      check("rst_ls_ready", {31'd0, ls_ready_o}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_we",      {31'd0, we_o}, 32'd0);
      check("rst_waddr",   {27'd0, waddr_o}, 32'd0);
      check("rst_wdata",   wdata_o, 32'd0);
      check("rst_pending", pending_o, 32'd0);
      check("rst_ex_ready_hold", {31'd0, ex_ready_o}, 32'd0);
      @(negedge clk);
      rst_in = 1'b0;
      ex_valid_i = 1'b0; ls_valid_i = 1'b0; issue_valid_i = 1'b0;
      m_pending = '0; m_waddr = '0; m_wdata = '0;
   endtask

   vec_t tbl[14];
   int   ex_cnt, ls_cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b1;
      issue_valid_i = 0; issue_rd_i = 0;
      ex_valid_i = 0; ex_rd_i = 0; ex_data_i = 0;
      ls_valid_i = 0; ls_rd_i = 0; ls_data_i = 0;
      raddr1_i = 0; raddr2_i = 0;
      m_pending = '0; m_waddr = '0; m_wdata = '0;

      //            ex_v rd  data          ls_v rd  data          iss rd  ra1 ra2 xe xl b1 b2
      tbl[0]  = mk(1, 5'd3, 32'h0000_00AA, 1, 5'd4, 32'h0000_00BB, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
      tbl[1]  = mk(0, 5'd0, 32'h0,         1, 5'd4, 32'h0000_00BB, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
      tbl[2]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd5, 5'd0, 0, 0, 1, 0);
      tbl[4]  = mk(1, 5'd5, 32'h0000_0055, 0, 5'd0, 32'h0,         0, 5'd0, 5'd5, 5'd0, 1, 0, 1, 0);
      tbl[5]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd5, 5'd5, 0, 0, 0, 0);
      tbl[6]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
      tbl[7]  = mk(1, 5'd7, 32'h0000_0077, 0, 5'd0, 32'h0,         1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 0);
      tbl[8]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0, 0, 0, 1, 0);
      tbl[9]  = mk(0, 5'd0, 32'h0,         1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
      tbl[10] = mk(1, 5'd7, 32'h0000_0070, 0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0, 1, 0, 1, 0);
      tbl[11] = mk(1, 5'd8, 32'h0000_0088, 1, 5'd9, 32'h0000_0099, 0, 5'd0, 5'd8, 5'd9, 0, 1, 0, 0);
      tbl[12] = mk(1, 5'd8, 32'h0000_0088, 1, 5'd10, 32'h0000_00A0, 0, 5'd0, 5'd9, 5'd0, 1, 0, 0, 0);
      tbl[13] = mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd8, 5'd10, 0, 0, 0, 0);

      // reset with both requesters valid: readies must stay low
      do_reset();

      for (int i = 0; i < 14; i++) step(tbl[i]);

      // sustained conflict: last grant was EX, so LS leads and grants alternate
      ex_cnt = 0; ls_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         vec_t v;
         v = mk(1, 5'(11 + k), $urandom, 1, 5'(20 + k), $urandom, 0, 5'd0, 5'd0, 5'd0,
                (k % 2) == 1, (k % 2) == 0, 0, 0);
         step(v);
         if (v.exp_ex) ex_cnt++;
         if (v.exp_ls) ls_cnt++;
      end
      check("ex_grant_count", ex_cnt, 4);
      check("ls_grant_count", ls_cnt, 4);

      // scoreboard 0x110 plus an in-flight write, then reset discards both
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd4, 5'd0, 5'd0, 0, 0, 0, 0));
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd8, 5'd4, 5'd0, 0, 0, 1, 0));
      step(mk(1, 5'd1, 32'h0000_0011, 0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd8, 1, 0, 1, 1));
      do_reset();

      // after reset EX wins the first conflict
      step(mk(1, 5'd2, 32'h0000_0022, 1, 5'd3, 32'h0000_0033, 0, 5'd0, 5'd4, 5'd8, 1, 0, 0, 0));
      step(mk(0, 5'd0, 32'h0, 1, 5'd3, 32'h0000_0033, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0));
      step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
